pe_dbuf: RTL and testbench

PE_DBUF -- requirements
Module: pe_dbuf

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_dot.sv | 45 ++++
 rtl/pe_dbuf.sv | 154 +++++++++++++++
 tb/tb_pe_dbuf.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the double-buffered MAC processing element:
// weight-buffer state encoding, default sizes and the lane-sum width helper.
package pe_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PSUM_WIDTH = 32;
  localparam int DEF_LANES      = 4;

  // Bit 1 = active bank valid, bit 0 = shadow bank valid.
  typedef enum logic [1:0] {
    WB_EMPTY  = 2'b00,
    WB_SHADOW = 2'b01,
    WB_ACTIVE = 2'b10,
    WB_FULL   = 2'b11
  } wbuf_state_e;

  // Full-precision sum of 'lanes' signed products of two data_width operands.
  function automatic int lane_sum_width(input int data_width, input int lanes);
    return 2 * data_width + $clog2(lanes);
  endfunction

endpackage

// File: rtl/pe_dot.sv
// Combinational multiply-and-reduce for pe_dbuf: per-lane signed products of the
// current operands, and the lane sum of the product vector held in stage 1.
module pe_dot
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic [LANES*DATA_WIDTH-1:0]                        w_vec,
  input  logic [LANES*DATA_WIDTH-1:0]                        x_vec,
  output logic [LANES*2*DATA_WIDTH-1:0]                      products,
  input  logic [LANES*2*DATA_WIDTH-1:0]                      reg_products,
  output logic signed [lane_sum_width(DATA_WIDTH, LANES)-1:0] lane_sum
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = lane_sum_width(DATA_WIDTH, LANES);

  logic signed [DATA_WIDTH-1:0] w_s;
  logic signed [DATA_WIDTH-1:0] x_s;
  logic signed [PROD_W-1:0]     p_s;

  always_comb begin
    products = '0;
    w_s      = '0;
    x_s      = '0;
    for (int l = 0; l < LANES; l++) begin
      w_s = w_vec[l*DATA_WIDTH +: DATA_WIDTH];
      x_s = x_vec[l*DATA_WIDTH +: DATA_WIDTH];
      products[l*PROD_W +: PROD_W] = PROD_W'(w_s) * PROD_W'(x_s);
    end
  end

  // Written as a chain; the sum is wide enough that no lane can overflow it,
  // so synthesis is free to rebalance it into a tree.
  always_comb begin
    lane_sum = '0;
    p_s      = '0;
    for (int l = 0; l < LANES; l++) begin
      p_s      = reg_products[l*PROD_W +: PROD_W];
      lane_sum = lane_sum + SUM_W'(p_s);
    end
  end

endmodule

// File: rtl/pe_dbuf.sv
// Systolic MAC processing element with shadow/active weight banks and a 2-stage
// MAC pipeline. Define PE_SAT_EN to saturate the partial-sum add instead of wrapping.
module pe_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LANES*DATA_WIDTH-1:0]   weight_i,
  input  logic                          weight_en_i,
  input  logic                          weight_swap_i,
  input  logic [LANES*DATA_WIDTH-1:0]   ifmap_i,
  input  logic                          ifmap_en_i,
  input  logic [PSUM_WIDTH-1:0]         psum_i,
  input  logic                          psum_en_i,
  output logic [LANES*DATA_WIDTH-1:0]   weight_o,
  output logic                          weight_en_o,
  output logic [LANES*DATA_WIDTH-1:0]   ifmap_o,
  output logic                          ifmap_en_o,
  output logic [PSUM_WIDTH-1:0]         psum_o,
  output logic                          psum_en_o,
  output logic [1:0]                    wbuf_state_o
);

  localparam int VEC_W  = LANES * DATA_WIDTH;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = lane_sum_width(DATA_WIDTH, LANES);

  wbuf_state_e               state_q;
  wbuf_state_e               state_d;
  logic                      do_swap;
  logic                      active_valid;
  logic [VEC_W-1:0]          shadow_w_q;
  logic [VEC_W-1:0]          active_w_q;
  logic [VEC_W-1:0]          mac_w;
  logic [LANES*PROD_W-1:0]   prod;
  logic [LANES*PROD_W-1:0]   prod_q;
  logic signed [SUM_W-1:0]   dot_sum;
  logic signed [PSUM_WIDTH-1:0] psum_q;
  logic signed [PSUM_WIDTH-1:0] ext_sum;
  logic signed [PSUM_WIDTH-1:0] psum_next;
  logic                      s1_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WB_EMPTY;
    else        state_q <= state_d;
  end

  // A swap only takes effect when the shadow bank holds valid weights; a load
  // in the same cycle becomes the new shadow, so the buffer stays FULL.
  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      WB_EMPTY:  if (weight_en_i) state_d = WB_SHADOW;
      WB_SHADOW: if (weight_swap_i) begin
                   do_swap = 1'b1;
                   state_d = weight_en_i ? WB_FULL : WB_ACTIVE;
                 end
      WB_ACTIVE: if (weight_en_i) state_d = WB_FULL;
      WB_FULL:   if (weight_swap_i) begin
                   do_swap = 1'b1;
                   state_d = weight_en_i ? WB_FULL : WB_ACTIVE;
                 end
      default:   state_d = WB_EMPTY;
    endcase
  end

  assign wbuf_state_o = state_q;
  assign active_valid = (state_q == WB_ACTIVE) || (state_q == WB_FULL);
  assign mac_w        = active_valid ? active_w_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_w_q <= '0;
      active_w_q <= '0;
    end else begin
      if (weight_en_i) shadow_w_q <= weight_i;
      if (do_swap)     active_w_q <= shadow_w_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight_o    <= '0;
      weight_en_o <= 1'b0;
      ifmap_o     <= '0;
      ifmap_en_o  <= 1'b0;
    end else begin
      weight_en_o <= weight_en_i;
      ifmap_en_o  <= ifmap_en_i;
      if (weight_en_i) weight_o <= weight_i;
      if (ifmap_en_i)  ifmap_o  <= ifmap_i;
    end
  end

  pe_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_dot (
    .w_vec        (mac_w),
    .x_vec        (ifmap_i),
    .products     (prod),
    .reg_products (prod_q),
    .lane_sum     (dot_sum)
  );

  // Stage 1 captures the products against the bank active this cycle, so a
  // swap landing on the same edge cannot reach an operation already issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= '0;
      psum_q  <= '0;
      s1_en_q <= 1'b0;
    end else begin
      s1_en_q <= psum_en_i;
      if (psum_en_i) begin
        prod_q <= prod;
        psum_q <= psum_i;
      end
    end
  end

  assign ext_sum = PSUM_WIDTH'(dot_sum);

`ifdef PE_SAT_EN
  logic [PSUM_WIDTH:0] psum_wide;

  always_comb begin
    psum_wide = {psum_q[PSUM_WIDTH-1], psum_q} + {ext_sum[PSUM_WIDTH-1], ext_sum};
    case (psum_wide[PSUM_WIDTH -: 2])
      2'b01:   psum_next = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
      2'b10:   psum_next = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
      default: psum_next = psum_wide[PSUM_WIDTH-1:0];
    endcase
  end
`else
  assign psum_next = psum_q + ext_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psum_o    <= '0;
      psum_en_o <= 1'b0;
    end else begin
      psum_en_o <= s1_en_q;
      if (s1_en_q) psum_o <= psum_next;
    end
  end

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed self-checking bench for pe_dbuf at LANES=4, DATA_WIDTH=8, PSUM_WIDTH=32.
// Expected saturation result follows PE_SAT_EN.
module tb_pe_dbuf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] weight_i;
  logic        weight_en_i;
  logic        weight_swap_i;
  logic [31:0] ifmap_i;
  logic        ifmap_en_i;
  logic [31:0] psum_i;
  logic        psum_en_i;
  logic [31:0] weight_o;
  logic        weight_en_o;
  logic [31:0] ifmap_o;
  logic        ifmap_en_o;
  logic [31:0] psum_o;
  logic        psum_en_o;
  logic [1:0]  wbuf_state_o;

  int vectors = 0;
  int fails   = 0;

`ifdef PE_SAT_EN
  localparam logic [31:0] EXP_OVF = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] EXP_OVF = 32'h8000_0054;
`endif

  pe_dbuf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .weight_i      (weight_i),
    .weight_en_i   (weight_en_i),
    .weight_swap_i (weight_swap_i),
    .ifmap_i       (ifmap_i),
    .ifmap_en_i    (ifmap_en_i),
    .psum_i        (psum_i),
    .psum_en_i     (psum_en_i),
    .weight_o      (weight_o),
    .weight_en_o   (weight_en_o),
    .ifmap_o       (ifmap_o),
    .ifmap_en_o    (ifmap_en_o),
    .psum_o        (psum_o),
    .psum_en_o     (psum_en_o),
    .wbuf_state_o  (wbuf_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    weight_en_i   = 1'b0;
    weight_swap_i = 1'b0;
    ifmap_en_i    = 1'b0;
    psum_en_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_weights(input logic [31:0] w);
    weight_i = w; weight_en_i = 1'b1;
    tick();
    weight_en_i = 1'b0;
  endtask

  task automatic swap_bank();
    weight_swap_i = 1'b1;
    tick();
    weight_swap_i = 1'b0;
  endtask

  // Issues one MAC and advances to the cycle in which its result is visible.
  task automatic mac(input logic [31:0] ifm, input logic [31:0] ps);
    ifmap_i = ifm; ifmap_en_i = 1'b1; psum_i = ps; psum_en_i = 1'b1;
    tick();
    ifmap_en_i = 1'b0; psum_en_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    weight_i = '0; ifmap_i = '0; psum_i = '0;
    tick(); tick();
    vectors++; if (psum_o !== 32'h0) begin fails++; $display("[TB] FAIL reset_psum got=%h exp=%h", psum_o, 32'h0); end
    vectors++; if (psum_en_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_psum_en got=%b exp=0", psum_en_o); end
    vectors++; if (wbuf_state_o !== 2'b00) begin fails++; $display("[TB] FAIL reset_state got=%b exp=00", wbuf_state_o); end
    vectors++; if ({weight_o, ifmap_o} !== 64'h0) begin fails++; $display("[TB] FAIL reset_fwd got=%h exp=0", {weight_o, ifmap_o}); end
    vectors++; if ({weight_en_o, ifmap_en_o} !== 2'b00) begin fails++; $display("[TB] FAIL reset_fwd_en got=%b exp=00", {weight_en_o, ifmap_en_o}); end
    rst_n = 1'b1;
  endtask

  task automatic test_empty_bank();
    do_reset();
    swap_bank();
    vectors++; if (wbuf_state_o !== 2'b00) begin fails++; $display("[TB] FAIL swap_in_empty got=%b exp=00", wbuf_state_o); end
    mac(32'h0A0A0A0A, 32'd7);
    vectors++; if (psum_en_o !== 1'b1 || psum_o !== 32'd7) begin fails++; $display("[TB] FAIL empty_mac got=%b/%h exp=1/%h", psum_en_o, psum_o, 32'd7); end
    load_weights(32'h01010101);
    vectors++; if (wbuf_state_o !== 2'b01) begin fails++; $display("[TB] FAIL shadow_only_state got=%b exp=01", wbuf_state_o); end
    mac(32'h0A0A0A0A, 32'd9);
    vectors++; if (psum_o !== 32'd9) begin fails++; $display("[TB] FAIL shadow_only_mac got=%h exp=%h", psum_o, 32'd9); end
  endtask

  task automatic test_basic_mac();
    do_reset();
    weight_i = 32'h04030201; weight_en_i = 1'b1;
    tick();
    vectors++; if (wbuf_state_o !== 2'b01) begin fails++; $display("[TB] FAIL load_state got=%b exp=01", wbuf_state_o); end
    vectors++; if (weight_o !== 32'h04030201 || weight_en_o !== 1'b1) begin fails++; $display("[TB] FAIL weight_fwd got=%h/%b exp=04030201/1", weight_o, weight_en_o); end
    weight_i = 32'hDEADBEEF; weight_en_i = 1'b0; weight_swap_i = 1'b1;
    tick();
    weight_swap_i = 1'b0;
    vectors++; if (wbuf_state_o !== 2'b10) begin fails++; $display("[TB] FAIL swap_state got=%b exp=10", wbuf_state_o); end
    vectors++; if (weight_o !== 32'h04030201 || weight_en_o !== 1'b0) begin fails++; $display("[TB] FAIL weight_hold got=%h/%b exp=04030201/0", weight_o, weight_en_o); end
    ifmap_i = 32'h0A0A0A0A; ifmap_en_i = 1'b1; psum_i = 32'd5; psum_en_i = 1'b1;
    tick();
    ifmap_en_i = 1'b0; psum_en_i = 1'b0; ifmap_i = 32'h55555555;
    vectors++; if (psum_en_o !== 1'b0) begin fails++; $display("[TB] FAIL latency_early got=%b exp=0", psum_en_o); end
    vectors++; if (ifmap_o !== 32'h0A0A0A0A || ifmap_en_o !== 1'b1) begin fails++; $display("[TB] FAIL ifmap_fwd got=%h/%b exp=0a0a0a0a/1", ifmap_o, ifmap_en_o); end
    tick();
    vectors++; if (psum_en_o !== 1'b1 || psum_o !== 32'd105) begin fails++; $display("[TB] FAIL basic_mac got=%b/%h exp=1/%h", psum_en_o, psum_o, 32'd105); end
    vectors++; if (ifmap_o !== 32'h0A0A0A0A || ifmap_en_o !== 1'b0) begin fails++; $display("[TB] FAIL ifmap_hold got=%h/%b exp=0a0a0a0a/0", ifmap_o, ifmap_en_o); end
    tick();
    vectors++; if (psum_en_o !== 1'b0 || psum_o !== 32'd105) begin fails++; $display("[TB] FAIL psum_hold got=%b/%h exp=0/%h", psum_en_o, psum_o, 32'd105); end
  endtask

  task automatic test_negative();
    load_weights(32'hFFFFFFFF);
    vectors++; if (wbuf_state_o !== 2'b11) begin fails++; $display("[TB] FAIL full_state got=%b exp=11", wbuf_state_o); end
    swap_bank();
    mac(32'h05040302, 32'd0);
    vectors++; if (psum_o !== 32'hFFFFFFF2) begin fails++; $display("[TB] FAIL negative_mac got=%h exp=fffffff2", psum_o); end
  endtask

  task automatic test_back_to_back();
    load_weights(32'h01010101);
    swap_bank();
    load_weights(32'h02020202);
    vectors++; if (wbuf_state_o !== 2'b11) begin fails++; $display("[TB] FAIL b2b_full got=%b exp=11", wbuf_state_o); end
    ifmap_i = 32'h01010101; ifmap_en_i = 1'b1; psum_i = 32'd0; psum_en_i = 1'b1; weight_swap_i = 1'b1;
    tick();
    weight_swap_i = 1'b0;
    vectors++; if (wbuf_state_o !== 2'b10) begin fails++; $display("[TB] FAIL b2b_swap_state got=%b exp=10", wbuf_state_o); end
    tick();
    psum_en_i = 1'b0; ifmap_en_i = 1'b0;
    vectors++; if (psum_en_o !== 1'b1 || psum_o !== 32'd4) begin fails++; $display("[TB] FAIL swap_same_cycle got=%b/%h exp=1/%h", psum_en_o, psum_o, 32'd4); end
    tick();
    vectors++; if (psum_en_o !== 1'b1 || psum_o !== 32'd8) begin fails++; $display("[TB] FAIL swap_next_cycle got=%b/%h exp=1/%h", psum_en_o, psum_o, 32'd8); end
    // Load and swap together while the shadow is valid: {3} becomes active, {5} shadow.
    load_weights(32'h03030303);
    weight_i = 32'h05050505; weight_en_i = 1'b1; weight_swap_i = 1'b1;
    tick();
    weight_en_i = 1'b0; weight_swap_i = 1'b0;
    vectors++; if (wbuf_state_o !== 2'b11) begin fails++; $display("[TB] FAIL load_swap_state got=%b exp=11", wbuf_state_o); end
    mac(32'h01010101, 32'd0);
    vectors++; if (psum_o !== 32'd12) begin fails++; $display("[TB] FAIL load_swap_active got=%h exp=%h", psum_o, 32'd12); end
    swap_bank();
    mac(32'h01010101, 32'd0);
    vectors++; if (psum_o !== 32'd20) begin fails++; $display("[TB] FAIL load_swap_shadow got=%h exp=%h", psum_o, 32'd20); end
  endtask

  task automatic test_overflow();
    load_weights(32'h04030201);
    swap_bank();
    mac(32'h0A0A0A0A, 32'h7FFFFFF0);
    vectors++; if (psum_o !== EXP_OVF) begin fails++; $display("[TB] FAIL overflow_add got=%h exp=%h", psum_o, EXP_OVF); end
  endtask

  task automatic test_reset_inflight();
    bit seen_en;
    ifmap_i = 32'h0A0A0A0A; ifmap_en_i = 1'b1; psum_i = 32'd5; psum_en_i = 1'b1;
    tick();
    psum_en_i = 1'b0;
    rst_n = 1'b0; weight_i = 32'hAAAAAAAA; weight_en_i = 1'b1;
    tick();
    rst_n = 1'b1; idle_inputs();
    vectors++; if ({weight_o, ifmap_o, psum_o} !== 96'h0) begin fails++; $display("[TB] FAIL rst_inflight_data got=%h exp=0", {weight_o, ifmap_o, psum_o}); end
    vectors++; if ({weight_en_o, ifmap_en_o, psum_en_o} !== 3'b000 || wbuf_state_o !== 2'b00) begin fails++; $display("[TB] FAIL rst_inflight_ctrl got=%b/%b exp=000/00", {weight_en_o, ifmap_en_o, psum_en_o}, wbuf_state_o); end
    seen_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (psum_en_o !== 1'b0) seen_en = 1'b1;
    end
    vectors++; if (seen_en !== 1'b0) begin fails++; $display("[TB] FAIL rst_discard got=%b exp=0", seen_en); end
  endtask

  initial begin
    test_reset();
    test_empty_bank();
    test_basic_mac();
    test_negative();
    test_back_to_back();
    test_overflow();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
